// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: mode codes, range-reduce FSM encoding and binary-angle constants.
package cordic_pkg;

  localparam logic [1:0] OP_ROTATE        = 2'b00;
  localparam logic [1:0] OP_VECTOR        = 2'b01;

  localparam logic [1:0] COORD_LINEAR     = 2'b00;
  localparam logic [1:0] COORD_CIRCULAR   = 2'b01;
  localparam logic [1:0] COORD_HYPERBOLIC = 2'b11;

  // Binary angles at 32 bits: 2^32 is a full turn.
  localparam logic [31:0] ANGLE_90  = 32'h4000_0000;
  localparam logic [31:0] ANGLE_180 = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_BUSY   = 2'b10
  } rr_state_t;

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Combinational pi-fold that maps circular-mode operands into the CORDIC convergence range.
// Build option CORDIC_RR_SAT_EN: negating the most-negative value saturates instead of wrapping.
module cordic_quadrant_fold
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]              mode_op_i,
  input  logic [1:0]              mode_coord_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [WIDTH-1:0] z_i,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] z_o,
  output logic                    fold_o
);

  localparam logic [WIDTH-1:0] HALF_TURN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
`ifdef CORDIC_RR_SAT_EN
    if (v == HALF_TURN) return ~HALF_TURN;
`endif
    return -v;
  endfunction

  always_comb begin
    fold_o = 1'b0;
    if (mode_coord_i == COORD_CIRCULAR) begin
      // Rotation: top two angle bits differ when |z| is past a quarter turn.
      if (mode_op_i == OP_ROTATE)      fold_o = z_i[WIDTH-1] ^ z_i[WIDTH-2];
      else if (mode_op_i == OP_VECTOR) fold_o = x_i[WIDTH-1];
    end
    x_o = fold_o ? negate(x_i) : x_i;
    y_o = fold_o ? negate(y_i) : y_i;
    z_o = fold_o ? (z_i ^ HALF_TURN) : z_i;
  end

endmodule

// File: rtl/cordic_range_reduce.sv
// Request front-end for a CORDIC core: folds operands, launches one job, waits for result-valid.
// Build option CORDIC_RR_SAT_EN selects saturating negation inside the fold.
//
// state     | meaning
// ST_IDLE   | s_ready high, waiting for a request
// ST_LAUNCH | c_enable pulse to the core, one cycle
// ST_BUSY   | c_* held stable until c_valid
module cordic_range_reduce
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [1:0]              s_mode_op,
  input  logic [1:0]              s_mode_coord,
  input  logic signed [WIDTH-1:0] s_x,
  input  logic signed [WIDTH-1:0] s_y,
  input  logic signed [WIDTH-1:0] s_z,
  output logic                    c_enable,
  output logic [1:0]              c_mode_op,
  output logic [1:0]              c_mode_coord,
  output logic signed [WIDTH-1:0] c_x,
  output logic signed [WIDTH-1:0] c_y,
  output logic signed [WIDTH-1:0] c_z,
  input  logic                    c_valid,
  output logic                    fold,
  output logic                    busy
);

  rr_state_t state_q, state_d;
  logic      take;

  logic signed [WIDTH-1:0] fx, fy, fz;
  logic                    ffold;

  logic signed [WIDTH-1:0] c_x_q, c_y_q, c_z_q;
  logic [1:0]              c_mode_op_q, c_mode_coord_q;
  logic                    fold_q;

  cordic_quadrant_fold #(.WIDTH(WIDTH)) u_fold (
    .mode_op_i    (s_mode_op),
    .mode_coord_i (s_mode_coord),
    .x_i          (s_x),
    .y_i          (s_y),
    .z_i          (s_z),
    .x_o          (fx),
    .y_o          (fy),
    .z_o          (fz),
    .fold_o       (ffold)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          take    = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY:   if (c_valid) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_x_q          <= '0;
      c_y_q          <= '0;
      c_z_q          <= '0;
      c_mode_op_q    <= '0;
      c_mode_coord_q <= '0;
      fold_q         <= 1'b0;
    end else if (take) begin
      c_x_q          <= fx;
      c_y_q          <= fy;
      c_z_q          <= fz;
      c_mode_op_q    <= s_mode_op;
      c_mode_coord_q <= s_mode_coord;
      fold_q         <= ffold;
    end
  end

  assign s_ready      = (state_q == ST_IDLE);
  assign c_enable     = (state_q == ST_LAUNCH);
  assign busy         = (state_q != ST_IDLE);
  assign c_x          = c_x_q;
  assign c_y          = c_y_q;
  assign c_z          = c_z_q;
  assign c_mode_op    = c_mode_op_q;
  assign c_mode_coord = c_mode_coord_q;
  assign fold         = fold_q;

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Scoreboard bench for cordic_range_reduce: driver pushes expected launches, monitor compares on c_enable.
module tb_cordic_range_reduce;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [1:0]   s_mode_op = 2'b00;
  logic [1:0]   s_mode_coord = 2'b00;
  logic [W-1:0] s_x = '0, s_y = '0, s_z = '0;
  logic         c_enable;
  logic [1:0]   c_mode_op, c_mode_coord;
  logic [W-1:0] c_x, c_y, c_z;
  logic         c_valid = 1'b0;
  logic         fold, busy;

  cordic_range_reduce #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_mode_op    (s_mode_op),
    .s_mode_coord (s_mode_coord),
    .s_x          (s_x),
    .s_y          (s_y),
    .s_z          (s_z),
    .c_enable     (c_enable),
    .c_mode_op    (c_mode_op),
    .c_mode_coord (c_mode_coord),
    .c_x          (c_x),
    .c_y          (c_y),
    .c_z          (c_z),
    .c_valid      (c_valid),
    .fold         (fold),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x, y, z;
    logic [1:0]   op, coord;
    logic         fold;
  } exp_t;

  exp_t q[$];
  exp_t held;
  logic held_ok = 1'b0;
  logic prev_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_launch = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: negate as a mathematical integer, then clip or wrap to W bits.
  function automatic logic [W-1:0] ref_neg(input logic [W-1:0] v);
    longint n;
    n = -longint'($signed(v));
`ifdef CORDIC_RR_SAT_EN
    if (n > 64'sd2147483647) n = 64'sd2147483647;
`endif
    return n[W-1:0];
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [1:0] coord,
                                 input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    exp_t   e;
    longint zs, xs, zu, zr;
    logic   f;
    zs = longint'($signed(z));
    xs = longint'($signed(x));
    f  = 1'b0;
    if (coord == 2'b01 && op == 2'b00)
      f = (zs >= 64'sd1073741824) || (zs < -64'sd1073741824);
    else if (coord == 2'b01 && op == 2'b01)
      f = (xs < 0);
    e.op = op; e.coord = coord; e.fold = f;
    e.x = x; e.y = y; e.z = z;
    if (f) begin
      zu  = longint'(z);
      zr  = (zu + 64'sd2147483648) % 64'sd4294967296;
      e.x = ref_neg(x);
      e.y = ref_neg(y);
      e.z = zr[W-1:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (c_enable) begin
      n_launch++;
      chk("enable_one_cycle", {127'd0, prev_en}, 128'd0);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_launch: got c_enable with no pending job, want none");
      end else begin
        held    = q.pop_front();
        held_ok = 1'b1;
        chk("launch_x",     {96'd0, c_x}, {96'd0, held.x});
        chk("launch_y",     {96'd0, c_y}, {96'd0, held.y});
        chk("launch_z",     {96'd0, c_z}, {96'd0, held.z});
        chk("launch_modes", {124'd0, c_mode_op, c_mode_coord}, {124'd0, held.op, held.coord});
        chk("launch_fold",  {127'd0, fold}, {127'd0, held.fold});
      end
    end else if (busy && held_ok) begin
      chk("busy_hold", {27'd0, c_x, c_y, c_z, c_mode_op, c_mode_coord, fold},
                       {27'd0, held.x, held.y, held.z, held.op, held.coord, held.fold});
    end
    if (!busy) held_ok = 1'b0;
    prev_en = c_enable;
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_enable"}, {127'd0, c_enable}, 128'd0);
    chk({tag, "_xyz"},    {32'd0, c_x, c_y, c_z}, 128'd0);
    chk({tag, "_modes"},  {124'd0, c_mode_op, c_mode_coord}, 128'd0);
    chk({tag, "_fold_busy"}, {126'd0, fold, busy}, 128'd0);
    chk({tag, "_ready"},  {127'd0, s_ready}, 128'd1);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {127'd0, s_ready}, 128'd1);
  endtask

  // Ends at the negedge of the LAUNCH cycle.
  task automatic start_job(input logic [1:0] op, input logic [1:0] coord,
                           input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    wait_ready();
    q.push_back(model(op, coord, x, y, z));
    s_mode_op = op; s_mode_coord = coord;
    s_x = x; s_y = y; s_z = z;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    chk("launch_latency", {127'd0, c_enable}, 128'd1);
  endtask

  task automatic finish_job(input int lat);
    repeat (lat) @(posedge clk);
    #1 c_valid = 1'b1;
    @(posedge clk);
    #1 c_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_busy", {127'd0, s_ready}, 128'd1);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'h4000_0000;
      2: return 32'hC000_0000;
      3: return 32'h3FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic handshake_test();
    wait_ready();
    q.push_back(model(2'b00, 2'b01, 32'h0000_1234, 32'h0000_0077, 32'h7000_0000));
    s_mode_op = 2'b00; s_mode_coord = 2'b01;
    s_x = 32'h0000_1234; s_y = 32'h0000_0077; s_z = 32'h7000_0000;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(model(2'b01, 2'b01, 32'hFFFF_0000, 32'h0000_0ABC, 32'h1111_1111));
    s_mode_op = 2'b01; s_x = 32'hFFFF_0000; s_y = 32'h0000_0ABC; s_z = 32'h1111_1111;
    fork
      begin
        @(negedge clk);
        repeat (40) @(posedge clk);
        #1 c_valid = 1'b1;
        @(posedge clk);
        #1 c_valid = 1'b0;
      end
      begin
        int low = 0;
        int en  = 0;
        @(negedge clk);
        while (!s_ready && low < 200) begin
          low++;
          if (c_enable) en++;
          @(negedge clk);
        end
        chk("ready_low_cycles", 128'(low), 128'd41);
        chk("launches_while_busy", 128'(en), 128'd1);
      end
    join
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    chk("second_launch", {127'd0, c_enable}, 128'd1);
    finish_job(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("in_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_cleared("after_reset");

    // 135 deg rotation fold
    start_job(2'b00, 2'b01, 32'h1000_0000, 32'h0, 32'h6000_0000);
    chk("rot_fold_const", {31'd0, c_x, c_y, c_z, fold}, {31'd0, 32'hF000_0000, 32'h0, 32'hE000_0000, 1'b1});
    finish_job(3);

    start_job(2'b00, 2'b01, 32'h1000_0000, 32'h10, 32'h2000_0000);
    chk("no_fold_const", {31'd0, c_x, c_y, c_z, fold}, {31'd0, 32'h1000_0000, 32'h10, 32'h2000_0000, 1'b0});
    finish_job(2);

    start_job(2'b01, 2'b01, 32'hFFFF_FF00, 32'h50, 32'h0);
    chk("vec_fold_const", {31'd0, c_x, c_y, c_z, fold}, {31'd0, 32'h100, 32'hFFFF_FFB0, 32'h8000_0000, 1'b1});
    finish_job(1);

    start_job(2'b01, 2'b01, 32'h8000_0000, 32'h0, 32'h0);
`ifdef CORDIC_RR_SAT_EN
    chk("neg_most_negative", {96'd0, c_x}, {96'd0, 32'h7FFF_FFFF});
`else
    chk("neg_most_negative", {96'd0, c_x}, {96'd0, 32'h8000_0000});
`endif
    finish_job(2);

    // Quadrant boundaries, linear/hyperbolic and unlisted codes
    start_job(2'b00, 2'b01, 32'h5, 32'h6, 32'h4000_0000); finish_job(1);
    start_job(2'b00, 2'b01, 32'h5, 32'h6, 32'h3FFF_FFFF); finish_job(1);
    start_job(2'b00, 2'b01, 32'h5, 32'h6, 32'hC000_0000); finish_job(1);
    start_job(2'b00, 2'b01, 32'h5, 32'h6, 32'hBFFF_FFFF); finish_job(1);
    start_job(2'b01, 2'b00, 32'hFFFF_0000, 32'h6, 32'h7000_0000); finish_job(2);
    start_job(2'b00, 2'b11, 32'hFFFF_0000, 32'h6, 32'h7000_0000); finish_job(2);
    start_job(2'b10, 2'b01, 32'hFFFF_0000, 32'h6, 32'h7000_0000); finish_job(2);
    start_job(2'b01, 2'b10, 32'hFFFF_0000, 32'h6, 32'h7000_0000); finish_job(2);

    // c_valid while idle or launching must not end a job
    base = n_launch;
    c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    @(negedge clk);
    chk("cvalid_idle_ready", {127'd0, s_ready}, 128'd1);
    chk("cvalid_idle_no_launch", 128'(n_launch), 128'(base));
    start_job(2'b00, 2'b01, 32'h22, 32'h33, 32'hA000_0000);
    c_valid = 1'b1;
    @(posedge clk);
    #1 c_valid = 1'b0;
    @(negedge clk);
    chk("cvalid_launch_ignored", {127'd0, s_ready}, 128'd0);
    finish_job(2);

    handshake_test();

    // Reset in the middle of a job
    start_job(2'b00, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32'h9000_0000);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_cleared("mid_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    base = n_launch;
    c_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 c_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_launch_after_reset", 128'(n_launch), 128'(base));
    check_cleared("post_reset_idle");

    for (int i = 0; i < 60; i++) begin
      logic [1:0] op, coord;
      op    = 2'($urandom_range(0, 3));
      coord = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
      start_job(op, coord, rnd_val(), rnd_val(), rnd_val());
      finish_job($urandom_range(1, 6));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 128'(q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_range_reduce.md
CORDIC_RANGE_REDUCE -- requirements
Module: cordic_range_reduce

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data/angle width; angles are binary-angle (2^WIDTH = 360 deg, 0x2000_0000 = 45 deg at 32).
REQ-002 SHALL have port clk  input  1  clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports s_valid input 1 / s_ready output 1: upstream request handshake.
REQ-005 SHALL have ports s_mode_op input 2 (00 rotation, 01 vectoring) and s_mode_coord input 2 (01 circular, 00 linear, 11 hyperbolic).
REQ-006 SHALL have ports s_x, s_y, s_z  input  WIDTH signed: request operands.
REQ-007 SHALL have ports c_enable output 1, c_mode_op output 2, c_mode_coord output 2, c_x/c_y/c_z output WIDTH signed: drive to the downstream CORDIC core.
REQ-008 SHALL have port c_valid  input  1: CORDIC core result-valid.
REQ-009 SHALL have ports fold  output 1 (pi-fold applied to current job) and busy  output 1 (state != IDLE).

Function
REQ-010 SHALL implement FSM IDLE -> LAUNCH -> BUSY -> IDLE.
REQ-011 SHALL assert s_ready only in IDLE; a transfer occurs when s_valid && s_ready at a rising edge.
REQ-012 On transfer SHALL register folded operands, modes and fold into c_* / fold, and enter LAUNCH.
REQ-013 SHALL assert c_enable for exactly one cycle, in LAUNCH only, then enter BUSY.
REQ-014 In BUSY SHALL hold all c_* outputs and fold stable; SHALL return to IDLE the cycle after c_valid is sampled high.
REQ-015 c_valid in IDLE or LAUNCH SHALL be ignored.
REQ-016 Circular rotation: fold=1 when s_z[W-1] != s_z[W-2] (|z| > 90 deg); then c_z = s_z with MSB inverted, c_x = -s_x, c_y = -s_y.
REQ-017 Circular vectoring: fold=1 when s_x < 0; then c_x = -s_x, c_y = -s_y, c_z = s_z with MSB inverted.
REQ-018 Linear, hyperbolic, and mode_op/mode_coord codes not listed: fold=0, operands passed unchanged.
REQ-019 Fold arithmetic SHALL be WIDTH-bit two's complement; angle add of 180 deg wraps modulo 2^WIDTH.
REQ-020 Minimum throughput: one job per (3 + core latency) cycles; s_ready rises the cycle after BUSY exits.

Reset
REQ-021 Asynchronous rst SHALL force state IDLE, c_enable=0, c_x/c_y/c_z=0, c_mode_op=0, c_mode_coord=0, fold=0, busy=0; s_ready=1 after release.
REQ-022 rst asserted mid-job (LAUNCH/BUSY) SHALL abandon the job; no c_enable pulse after release until a new transfer.

Configuration
REQ-023 Macro CORDIC_RR_SAT_EN defined: negation of most-negative value (0x8000_0000 at 32) SHALL saturate to most-positive (0x7FFF_FFFF).
REQ-024 Macro CORDIC_RR_SAT_EN undefined: negation SHALL wrap (-0x8000_0000 = 0x8000_0000).

Structure
REQ-025 Shared package cordic_pkg SHALL hold mode_op/mode_coord codes, FSM state encoding, and ANGLE_90/ANGLE_180 constants.
REQ-026 Fold logic SHALL be combinational sub-module cordic_quadrant_fold; FSM and registers stay in top.

Verification
REQ-027 Rotation fold: circular rotation, z=0x6000_0000 (135 deg), x=0x1000_0000, y=0 -> c_z=0xE000_0000, c_x=0xF000_0000, c_y=0, fold=1.
REQ-028 No fold: circular rotation, z=0x2000_0000, x=0x1000_0000, y=0x10 -> operands unchanged, fold=0; c_enable one cycle exactly one cycle after transfer.
REQ-029 Vectoring fold: x=-0x100, y=0x50, z=0 -> c_x=0x100, c_y=0xFFFF_FFB0, c_z=0x8000_0000, fold=1.
REQ-030 Handshake: s_valid held high with c_valid delayed 40 cycles -> s_ready low for 41 cycles, c_* stable, second job launches only after c_valid.
REQ-031 Reset mid-BUSY: rst pulse in BUSY -> all outputs 0, s_ready=1, late c_valid ignored, no c_enable.
REQ-032 Saturation: vectoring x=0x8000_0000 -> c_x=0x7FFF_FFFF with CORDIC_RR_SAT_EN, 0x8000_0000 without.
